// File: rtl/frame_pingpong_pkg.sv
// Shared defaults for the frame ping-pong buffer.
package frame_pingpong_pkg;

   localparam int DEF_WIDTH = 12;
   localparam int DEF_H_RES = 320;
   localparam int DEF_V_RES = 240;

   typedef logic [DEF_WIDTH-1:0] pixel_t;

   // Address bits needed for one frame bank.
   function automatic int frame_addr_w(input int h_res, input int v_res);
      return $clog2(h_res * v_res);
   endfunction

endpackage

// File: rtl/frame_pingpong_ram_sdp.sv
// Single-clock simple dual-port RAM with registered read output.
// Read and write to the same word on one edge return the old word.
module sdp_ram #(
   parameter int WIDTH = 12,
   parameter int AW    = 8
) (
   input  logic             clk_i,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [2**AW];
   logic [WIDTH-1:0] r_rdata;

   // Storage write and registered read; contents are never reset.
   always_ff @(posedge clk_i) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_pingpong_ram.sv
// Double-buffered frame store: the writer fills one bank while the reader
// reads the other; banks swap one cycle after a frame completes unless the
// reader holds. Optional macro FRAME_PINGPONG_SHORT_ERR_EN flags frames
// restarted by an early start-of-frame.
module frame_pingpong_ram
   import frame_pingpong_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              wr_valid_i,
   input  logic              wr_sof_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [frame_addr_w(H_RES, V_RES)-1:0] rd_address_i,
   input  logic              rd_hold_i,
   output logic [WIDTH-1:0]  rd_data_o,
   output logic              frame_valid_o,
   output logic              frame_done_o,
   output logic [15:0]       frame_count_o,
   output logic [7:0]        drop_count_o,
   output logic              short_frame_o
);

   localparam int DEPTH  = H_RES * V_RES;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic              r_wr_bank;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_swap_pend;
   logic              r_frame_done;
   logic              r_frame_valid;
   logic [15:0]       r_frame_count;
   logic [7:0]        r_drop_count;
   logic              r_rd_zero;

   logic [ADDR_W-1:0] w_addr;
   logic              w_last;
   logic              w_bank;
   logic [WIDTH-1:0]  w_ram_q;

   // A start-of-frame pixel always lands at address 0.
   assign w_addr = wr_sof_i ? '0 : r_wr_addr;
   assign w_last = wr_valid_i && (w_addr == LAST_ADDR);
   // Once a frame is complete and a swap is pending, new pixels already
   // belong to the bank that becomes the write bank at the swap edge.
   assign w_bank = r_wr_bank ^ r_swap_pend;

   // Write pointer, bank swap, frame/drop accounting.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_bank     <= 1'b0;
         r_wr_addr     <= '0;
         r_swap_pend   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_count <= '0;
         r_drop_count  <= '0;
      end else begin
         if (wr_valid_i) r_wr_addr <= w_last ? '0 : w_addr + ADDR_W'(1);
         r_swap_pend  <= w_last & ~rd_hold_i;
         r_frame_done <= r_swap_pend;
         if (r_swap_pend) begin
            r_wr_bank     <= ~r_wr_bank;
            r_frame_count <= r_frame_count + 16'd1;
            r_frame_valid <= 1'b1;
         end
         if (w_last && rd_hold_i && r_drop_count != 8'hFF)
            r_drop_count <= r_drop_count + 8'd1;
      end
   end

   // Out-of-range reads are zeroed at the output; reset also forces zero.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)     r_rd_zero <= 1'b1;
      else if (rd_en_i) r_rd_zero <= ({1'b0, rd_address_i} >= DEPTH_EXT);
   end

`ifdef FRAME_PINGPONG_SHORT_ERR_EN
   logic r_short;

   // Sticky flag: start-of-frame arrived before the frame was complete.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_short <= 1'b0;
      else if (wr_valid_i && wr_sof_i && r_wr_addr != '0) r_short <= 1'b1;
   end

   assign short_frame_o = r_short;
`else
   assign short_frame_o = 1'b0;
`endif

   // Bank bit is the address MSB; read bank is always the non-write bank.
   sdp_ram #(.WIDTH(WIDTH), .AW(ADDR_W + 1)) u_ram (
      .clk_i   (clk_i),
      .i_we    (wr_valid_i),
      .i_waddr ({w_bank, w_addr}),
      .i_wdata (wr_data_i),
      .i_re    (rd_en_i),
      .i_raddr ({~r_wr_bank, rd_address_i}),
      .o_rdata (w_ram_q)
   );

   assign rd_data_o     = r_rd_zero ? '0 : w_ram_q;
   assign frame_valid_o = r_frame_valid;
   assign frame_done_o  = r_frame_done;
   assign frame_count_o = r_frame_count;
   assign drop_count_o  = r_drop_count;

endmodule

// File: tb/tb_frame_pingpong_ram.sv
// Scoreboard bench for frame_pingpong_ram (4x2 frames) plus a 3x3 instance
// for out-of-range read addresses.
module tb_frame_pingpong_ram;

   localparam int DEPTH = 8;
`ifdef FRAME_PINGPONG_SHORT_ERR_EN
   localparam bit SHORT_EN = 1'b1;
`else
   localparam bit SHORT_EN = 1'b0;
`endif

   typedef struct {
      int rd; int done; int valid; int cnt; int drop; int shrt;
   } exp_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        wr_valid = 0, wr_sof = 0, rd_en = 0, rd_hold = 0;
   logic [11:0] wr_data = 0;
   logic [2:0]  rd_addr = 0;
   logic [11:0] rd_data;
   logic        frame_valid, frame_done, short_frame;
   logic [15:0] frame_count;
   logic [7:0]  drop_count;

   // second instance: DEPTH=9, 4-bit read address
   logic        o2_wv = 0, o2_sof = 0, o2_re = 0, o2_hold = 0;
   logic [11:0] o2_wd = 0;
   logic [3:0]  o2_ra = 0;
   logic [11:0] o2_rd;
   logic        o2_fv, o2_fd, o2_sf;
   logic [15:0] o2_fc;
   logic [7:0]  o2_dc;

   int checks = 0, failures = 0;
   exp_t sb[$];

   // reference state
   int mem[2][DEPTH];
   int m_wa, m_wrb, m_pend, m_done, m_cnt, m_drop, m_valid, m_short, m_rd;

   always #5 clk = ~clk;

   frame_pingpong_ram #(.WIDTH(12), .H_RES(4), .V_RES(2)) dut (
      .clk_i(clk), .reset_i(rst_n), .wr_valid_i(wr_valid), .wr_sof_i(wr_sof),
      .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_address_i(rd_addr),
      .rd_hold_i(rd_hold), .rd_data_o(rd_data), .frame_valid_o(frame_valid),
      .frame_done_o(frame_done), .frame_count_o(frame_count),
      .drop_count_o(drop_count), .short_frame_o(short_frame));

   frame_pingpong_ram #(.WIDTH(12), .H_RES(3), .V_RES(3)) dut_oor (
      .clk_i(clk), .reset_i(rst_n), .wr_valid_i(o2_wv), .wr_sof_i(o2_sof),
      .wr_data_i(o2_wd), .rd_en_i(o2_re), .rd_address_i(o2_ra),
      .rd_hold_i(o2_hold), .rd_data_o(o2_rd), .frame_valid_o(o2_fv),
      .frame_done_o(o2_fd), .frame_count_o(o2_fc),
      .drop_count_o(o2_dc), .short_frame_o(o2_sf));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // One clock edge of the reference: reads see the displayed bank before
   // this edge's write or swap takes effect.
   task automatic model_edge();
      int  a;
      bit  newpend;
      newpend = 0;
      if (!rst_n) begin
         m_wa = 0; m_wrb = 0; m_pend = 0; m_done = 0; m_cnt = 0;
         m_drop = 0; m_valid = 0; m_short = 0; m_rd = 0;
         return;
      end
      if (rd_en) m_rd = (int'(rd_addr) >= DEPTH) ? 0 : mem[1 - m_wrb][rd_addr];
      if (wr_valid) begin
         a = wr_sof ? 0 : m_wa;
         if (wr_sof && m_wa != 0 && SHORT_EN) m_short = 1;
         mem[m_wrb ^ m_pend][a] = int'(wr_data);
         if (a == DEPTH - 1) begin
            m_wa = 0;
            if (rd_hold) begin
               if (m_drop < 255) m_drop++;
            end else newpend = 1;
         end else m_wa = a + 1;
      end
      m_done = m_pend;
      if (m_pend) begin
         m_wrb ^= 1;
         m_cnt = (m_cnt + 1) & 16'hFFFF;
         m_valid = 1;
      end
      m_pend = newpend;
   endtask

   task automatic step(input bit v, input bit s, input int d, input bit re,
                       input int ra, input bit h);
      exp_t e;
      @(negedge clk);
      wr_valid = v; wr_sof = s; wr_data = 12'(d);
      rd_en = re; rd_addr = 3'(ra); rd_hold = h;
      @(posedge clk);
      model_edge();
      e.rd = m_rd; e.done = m_done; e.valid = m_valid; e.cnt = m_cnt;
      e.drop = m_drop; e.shrt = m_short;
      sb.push_back(e);
      #1;
   endtask

   task automatic step2(input bit v, input bit s, input int d, input bit re,
                        input int ra);
      @(negedge clk);
      o2_wv = v; o2_sof = s; o2_wd = 12'(d); o2_re = re; o2_ra = 4'(ra);
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are presented every cycle; compare against the
   // oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.rd >= 0) chk("sb_rd_data", int'(rd_data), e.rd);
         chk("sb_frame_done", int'(frame_done), e.done);
         chk("sb_frame_valid", int'(frame_valid), e.valid);
         chk("sb_frame_count", int'(frame_count), e.cnt);
         chk("sb_drop_count", int'(drop_count), e.drop);
         chk("sb_short_frame", int'(short_frame), e.shrt);
      end
   end

   initial begin
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < DEPTH; i++) mem[b][i] = -1;

      // power-on reset, then a partial frame interrupted by reset
      repeat (2) step(0, 0, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 3; i++) step(1, i == 0, 12'h0F0 + i, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      sb.delete();
      rst_n = 0;
      #1;
      model_edge();
      chk("rst_rd_data", int'(rd_data), 0);
      chk("rst_frame_valid", int'(frame_valid), 0);
      chk("rst_frame_done", int'(frame_done), 0);
      chk("rst_frame_count", int'(frame_count), 0);
      chk("rst_drop_count", int'(drop_count), 0);
      chk("rst_short", int'(short_frame), 0);
      repeat (2) step(0, 0, 0, 0, 0, 0);
      @(negedge clk); rst_n = 1;

      // frame 1
      for (int i = 0; i < 8; i++) step(1, i == 0, 1 + i, 0, 0, 0);
      chk("f1_done_early", int'(frame_done), 0);
      step(0, 0, 0, 0, 0, 0);
      chk("f1_done", int'(frame_done), 1);
      chk("f1_count", int'(frame_count), 1);
      chk("f1_valid", int'(frame_valid), 1);
      step(0, 0, 0, 1, 3, 0);
      chk("f1_rd3", int'(rd_data), 12'h004);
      chk("f1_done_pulse", int'(frame_done), 0);

      // frame 2 while reading address 0
      for (int i = 0; i < 8; i++) begin
         step(1, i == 0, 12'h011 + i, 1, 0, 0);
         chk("f2_rd_old", int'(rd_data), 12'h001);
      end
      step(0, 0, 0, 1, 0, 0);
      chk("f2_rd_swap_edge", int'(rd_data), 12'h001);
      chk("f2_done", int'(frame_done), 1);
      step(0, 0, 0, 1, 0, 0);
      chk("f2_rd_new", int'(rd_data), 12'h011);
      chk("f2_count", int'(frame_count), 2);

      // frame 3 completes under hold
      for (int i = 0; i < 8; i++) step(1, i == 0, 12'h021 + i, 0, 0, i == 7);
      step(0, 0, 0, 1, 0, 0);
      chk("f3_no_done", int'(frame_done), 0);
      chk("f3_drop", int'(drop_count), 1);
      chk("f3_count", int'(frame_count), 2);
      step(0, 0, 0, 1, 0, 0);
      chk("f3_rd_kept", int'(rd_data), 12'h011);

      // early sof after 5 pixels, then a full frame
      for (int i = 0; i < 5; i++) step(1, i == 0, 12'h030 + i, 0, 0, 0);
      step(1, 1, 12'h031, 0, 0, 0);
      chk("short_flag", int'(short_frame), int'(SHORT_EN));
      chk("short_count", int'(frame_count), 2);
      for (int i = 1; i < 8; i++) step(1, 0, 12'h031 + i, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("f4_done", int'(frame_done), 1);
      chk("f4_count", int'(frame_count), 3);
      step(0, 0, 0, 1, 0, 0);
      chk("f4_rd0", int'(rd_data), 12'h031);
      step(0, 0, 0, 1, 7, 0);
      chk("f4_rd7", int'(rd_data), 12'h038);

      // randomized traffic against the reference
      for (int n = 0; n < 1500; n++) begin
         bit v, s, re, h;
         v  = ($urandom_range(0, 9) < 7);
         s  = v && ($urandom_range(0, 9) == 0);
         re = ($urandom_range(0, 9) < 6);
         h  = ($urandom_range(0, 4) == 0);
         step(v, s, int'($urandom_range(0, 4095)), re,
              int'($urandom_range(0, 7)), h);
      end
      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);

      // out-of-range reads on the 3x3 instance
      for (int i = 0; i < 9; i++) step2(1, i == 0, 12'h0A0 + i, 0, 0);
      step2(0, 0, 0, 0, 0);
      step2(0, 0, 0, 1, 0);
      chk("oor_rd0", int'(o2_rd), 12'h0A0);
      step2(0, 0, 0, 1, 9);
      chk("oor_rd9", int'(o2_rd), 0);
      step2(0, 0, 0, 1, 8);
      chk("oor_rd8", int'(o2_rd), 12'h0A8);
      step2(0, 0, 0, 1, 15);
      chk("oor_rd15", int'(o2_rd), 0);
      step2(0, 0, 0, 1, 4);
      chk("oor_rd4", int'(o2_rd), 12'h0A4);
      step2(0, 0, 0, 0, 9);
      chk("oor_hold", int'(o2_rd), 12'h0A4);
      chk("oor_count", int'(o2_fc), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
